bayer_binner: RTL and testbench
===============================

BAYER_BINNER -- requirements
Module: bayer_binner

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 640, meaning raw sensor pixels per line; even only.
REQ-002 SHALL have parameter IN_HEIGHT, default 480, meaning raw sensor lines per frame; even only.
REQ-003 piul1Clock  input  1  single clock; sensor pixel clock domain; all logic on its rising edge.
REQ-004 piul1Reset_n  input  1  asynchronous, active-low reset.
REQ-005 piul1FrameValid  input  1  sensor frame valid.
REQ-006 piul1LineValid  input  1  sensor line valid.
REQ-007 piul12PixelData  input  12  raw Bayer pixel, GRBG order (even row G1,R,...; odd row B,G2,...).
REQ-008 poul1Update  output  1  one-cycle strobe: position and colour outputs valid for the DrawPoint stage.
REQ-009 poul9PosX  output  9  binned column, 0..IN_WIDTH/2-1.
REQ-010 poul9PosY  output  9  binned row, 0..IN_HEIGHT/2-1.
REQ-011 poul12Rgb12Data  output  12  {R[3:0],G[3:0],B[3:0]}.
REQ-012 poul1FrameDone  output  1  one-cycle strobe at end of frame.

Function
REQ-013 A pixel SHALL be accepted when FrameValid & LineValid are both 1 on a rising edge.
REQ-014 The FSM SHALL have two states: WAIT_FRAME and ACTIVE; WAIT_FRAME->ACTIVE on a FrameValid 0->1 edge; ACTIVE->WAIT_FRAME on FrameValid 1->0.
REQ-015 On entering ACTIVE, the column and row counters SHALL clear to 0.
REQ-016 Column counter SHALL increment per accepted pixel; it SHALL clear and the row counter SHALL increment on each LineValid 1->0 edge in ACTIVE.
REQ-017 Pixels with column >= IN_WIDTH or row >= IN_HEIGHT SHALL be ignored; the counters SHALL saturate and not wrap.
REQ-018 On even rows, each G1 (even column) and R (odd column) pair SHALL be written to a line buffer of IN_WIDTH/2 entries x 24 bits, indexed by column>>1.
REQ-019 On odd rows, B (even column) SHALL be held; at the G2 pixel (odd column), the buffer entry SHALL be read and one binned pixel SHALL be produced.
REQ-020 Colour: R=R[11:8]; B=B[11:8]; G=((G1+G2) 13-bit sum)>>1, taking bits [11:8] of the result.
REQ-021 poul1Update SHALL pulse exactly one cycle, registered, in the cycle after the G2 pixel is accepted; PosX=column>>1 and PosY=row>>1 of that quad.
REQ-022 PosX, PosY and Rgb12Data SHALL hold their values until the next Update.
REQ-023 A line shorter than IN_WIDTH SHALL emit only complete quads; stale buffer entries beyond the even-row length SHALL still be used if the odd row is longer.
REQ-024 FrameValid 1->0 mid-line SHALL abort: no further Update; FrameDone SHALL pulse one cycle later.
REQ-025 FrameDone SHALL pulse one cycle after every FrameValid 1->0 seen in ACTIVE, including a normal frame end.
REQ-026 Full-frame throughput SHALL be IN_WIDTH*IN_HEIGHT/4 Updates per frame, with no back-pressure.

Reset
REQ-027 On reset assertion, all outputs SHALL go to 0 and the FSM to WAIT_FRAME, asynchronously.
REQ-028 Reset SHALL release synchronously to piul1Clock.
REQ-029 Line buffer contents SHALL NOT require reset.
REQ-030 Reset mid-frame followed by release while FrameValid=1 SHALL stay in WAIT_FRAME until the next FrameValid rising edge.

Configuration
REQ-031 Macro BAYER_BINNER_TEST_PATTERN_EN SHALL be used; when defined, it adds input piul1TestPattern (1 bit).
REQ-032 With BAYER_BINNER_TEST_PATTERN_EN defined and piul1TestPattern=1, Rgb12Data SHALL be {PosX[8:5],PosY[7:4],4'h0}; timing and positions SHALL be unchanged.
REQ-033 With BAYER_BINNER_TEST_PATTERN_EN not defined, the port and the pattern logic SHALL be absent and the output SHALL always be the binned colour.

Verification
REQ-034 Flat frame 640x480 (G=0xA00, R=0xF00, B=0x100) -> 76800 Updates; each Rgb12=0xFA1; last Update PosX=319, PosY=239; one FrameDone.
REQ-035 G1=0x800, G2=0x9FF at quad (0,0) -> G nibble 0x8 (sum 0x11FF>>1=0x8FF); Update one cycle after the G2 pixel.
REQ-036 Line of 700 pixels -> pixels 640..699 ignored; PosX never exceeds 319.
REQ-037 FrameValid dropped at row 101, column 300 -> no Update after the drop; FrameDone pulses once; the next frame restarts at PosX=0, PosY=0.
REQ-038 Reset asserted mid-line -> all outputs 0 immediately; no Update until the next FrameValid rising edge.
REQ-039 With BAYER_BINNER_TEST_PATTERN_EN defined and TestPattern=1 -> quad (PosX=100, PosY=50) gives Rgb12=0x330.

Source files
------------

// File: rtl/bayer_binner.sv
`default_nettype none
// ============================================================================
// Module   : bayer_binner
// Purpose  : 2x2 GRBG Bayer binning to 12-bit RGB points; optional test
//            pattern output enabled by macro BAYER_BINNER_TEST_PATTERN_EN.
// Revision : 1.0
// ============================================================================
module bayer_binner #(
    parameter int IN_WIDTH  = 640,
    parameter int IN_HEIGHT = 480
) (
    input  logic        piul1Clock,
    input  logic        piul1Reset_n,
    input  logic        piul1FrameValid,
    input  logic        piul1LineValid,
    input  logic [11:0] piul12PixelData,
`ifdef BAYER_BINNER_TEST_PATTERN_EN
    input  logic        piul1TestPattern,
`endif
    output logic        poul1Update,
    output logic [8:0]  poul9PosX,
    output logic [8:0]  poul9PosY,
    output logic [11:0] poul12Rgb12Data,
    output logic        poul1FrameDone
);

    localparam int COL_W     = $clog2(IN_WIDTH + 1);
    localparam int ROW_W     = $clog2(IN_HEIGHT + 1);
    localparam int BUF_DEPTH = IN_WIDTH / 2;
    localparam int ADDR_W    = $clog2(BUF_DEPTH);

    typedef enum logic [0:0] {
        WAIT_FRAME = 1'b0,
        ACTIVE     = 1'b1
    } state_t;

    state_t           state_q;
    logic             fv_q;
    logic             lv_q;
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    logic [11:0]      g1_q;
    logic [3:0]       b_q;
    logic [23:0]      line_buf [BUF_DEPTH];

    logic             w_start;
    logic             w_in_frame;
    logic             w_line_end;
    logic             w_in_range;
    logic             w_pix_ok;
    logic [COL_W-1:0] w_col;
    logic [ROW_W-1:0] w_row;
    logic [COL_W-1:0] w_col_d;
    logic [ROW_W-1:0] w_row_d;
    logic [ADDR_W-1:0] w_addr;
    logic [23:0]      w_rd;
    logic [12:0]      w_g_sum;
    logic [8:0]       w_posx;
    logic [8:0]       w_posy;
    logic [11:0]      w_rgb_bin;
    logic [11:0]      w_rgb_d;
    logic             w_unused_bits;

    // The rising-edge cycle already counts as column/row zero so a pixel
    // arriving together with FrameValid is not lost.
    assign w_start    = (state_q == WAIT_FRAME) && piul1FrameValid && !fv_q;
    assign w_in_frame = w_start || ((state_q == ACTIVE) && piul1FrameValid);
    assign w_line_end = (state_q == ACTIVE) && piul1FrameValid && lv_q && !piul1LineValid;
    assign w_col      = w_start ? '0 : col_q;
    assign w_row      = w_start ? '0 : row_q;
    assign w_in_range = (w_col < COL_W'(IN_WIDTH)) && (w_row < ROW_W'(IN_HEIGHT));
    assign w_pix_ok   = w_in_frame && piul1LineValid && w_in_range;

    always_comb begin
        w_col_d = w_col;
        w_row_d = w_row;
        if (w_line_end) begin
            w_col_d = '0;
            if (w_row < ROW_W'(IN_HEIGHT)) begin
                w_row_d = w_row + ROW_W'(1);
            end
        end else if (piul1LineValid && (w_col < COL_W'(IN_WIDTH))) begin
            w_col_d = w_col + COL_W'(1);
        end
    end

    assign w_addr    = ADDR_W'(w_col >> 1);
    assign w_rd      = line_buf[w_addr];
    assign w_g_sum   = {1'b0, w_rd[23:12]} + {1'b0, piul12PixelData};
    assign w_posx    = 9'(w_col >> 1);
    assign w_posy    = 9'(w_row >> 1);
    assign w_rgb_bin = {w_rd[11:8], w_g_sum[12:9], b_q};
    assign w_unused_bits = ^w_rd[7:0];

`ifdef BAYER_BINNER_TEST_PATTERN_EN
    assign w_rgb_d = piul1TestPattern ? {w_posx[8:5], w_posy[7:4], 4'h0} : w_rgb_bin;
`else
    assign w_rgb_d = w_rgb_bin;
`endif

    // Line buffer holds {G1, R} of the even row; no reset needed.
    always_ff @(posedge piul1Clock) begin
        if (w_pix_ok && !w_row[0] && w_col[0]) begin
            line_buf[w_addr] <= {g1_q, piul12PixelData};
        end
    end

    always_ff @(posedge piul1Clock or negedge piul1Reset_n) begin
        if (!piul1Reset_n) begin
            state_q         <= WAIT_FRAME;
            fv_q            <= 1'b1;
            lv_q            <= 1'b0;
            col_q           <= '0;
            row_q           <= '0;
            g1_q            <= '0;
            b_q             <= '0;
            poul1Update     <= 1'b0;
            poul9PosX       <= '0;
            poul9PosY       <= '0;
            poul12Rgb12Data <= '0;
            poul1FrameDone  <= 1'b0;
        end else begin
            fv_q           <= piul1FrameValid;
            lv_q           <= piul1LineValid;
            poul1Update    <= 1'b0;
            poul1FrameDone <= 1'b0;

            if (state_q == WAIT_FRAME) begin
                if (w_start) begin
                    state_q <= ACTIVE;
                end
            end else if (!piul1FrameValid) begin
                state_q        <= WAIT_FRAME;
                poul1FrameDone <= 1'b1;
            end

            if (w_in_frame) begin
                col_q <= w_col_d;
                row_q <= w_row_d;
            end

            if (w_pix_ok) begin
                if (!w_col[0]) begin
                    if (w_row[0]) begin
                        b_q <= piul12PixelData[11:8];
                    end else begin
                        g1_q <= piul12PixelData;
                    end
                end else if (w_row[0]) begin
                    poul1Update     <= 1'b1;
                    poul9PosX       <= w_posx;
                    poul9PosY       <= w_posy;
                    poul12Rgb12Data <= w_rgb_d;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bayer_binner.sv
`default_nettype none
// ============================================================================
// Module   : tb_bayer_binner
// Purpose  : Directed scoreboard bench for bayer_binner on a reduced frame.
// Revision : 1.0
// ============================================================================
module tb_bayer_binner;

    localparam int W = 80;
    localparam int H = 12;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        fv    = 1'b0;
    logic        lv    = 1'b0;
    logic [11:0] pix   = 12'h000;
    logic        tp    = 1'b0;

    logic        upd;
    logic [8:0]  pos_x;
    logic [8:0]  pos_y;
    logic [11:0] rgb;
    logic        done;

    bayer_binner #(.IN_WIDTH(W), .IN_HEIGHT(H)) dut (
        .piul1Clock      (clk),
        .piul1Reset_n    (rst_n),
        .piul1FrameValid (fv),
        .piul1LineValid  (lv),
        .piul12PixelData (pix),
`ifdef BAYER_BINNER_TEST_PATTERN_EN
        .piul1TestPattern(tp),
`endif
        .poul1Update     (upd),
        .poul9PosX       (pos_x),
        .poul9PosY       (pos_y),
        .poul12Rgb12Data (rgb),
        .poul1FrameDone  (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [8:0]  x;
        logic [8:0]  y;
        logic [11:0] rgb;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          n_upd = 0;
    int          n_fd = 0;
    logic [8:0]  last_x = '0, last_y = '0, max_x = '0;
    logic [11:0] last_rgb = '0;
    logic [23:0] mbuf [W/2];
    logic [11:0] m_g1 = '0, m_b = '0;

    // Monitor: every Update is matched against the scoreboard, and the
    // position/colour outputs must hold between Updates.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last_x   = '0;
            last_y   = '0;
            last_rgb = '0;
        end else begin
            if (done) n_fd++;
            if (upd) begin
                n_upd++;
                n_cmp++;
                assert (q.size() > 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_update: observed x=%0d y=%0d, expected no update", pos_x, pos_y);
                end
                if (q.size() > 0) begin
                    e = q.pop_front();
                    n_cmp++;
                    assert ({pos_x, pos_y, rgb} === {e.x, e.y, e.rgb} && cyc == e.cyc) else begin
                        n_fail++;
                        $error("FAIL update_data: observed x=%0d y=%0d rgb=%h cyc=%0d, expected x=%0d y=%0d rgb=%h cyc=%0d",
                               pos_x, pos_y, rgb, cyc, e.x, e.y, e.rgb, e.cyc);
                    end
                end
                last_x   = pos_x;
                last_y   = pos_y;
                last_rgb = rgb;
                if (pos_x > max_x) max_x = pos_x;
            end else begin
                n_cmp++;
                assert ({pos_x, pos_y, rgb} === {last_x, last_y, last_rgb}) else begin
                    n_fail++;
                    $error("FAIL output_hold: observed x=%0d y=%0d rgb=%h, expected x=%0d y=%0d rgb=%h",
                           pos_x, pos_y, rgb, last_x, last_y, last_rgb);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic send_pix(input int r, input int c, input logic [11:0] p, input bit track);
        exp_t        e;
        logic [12:0] gs;
        logic [12:0] gh;
        fv  = 1'b1;
        lv  = 1'b1;
        pix = p;
        if (track && r < H && c < W) begin
            if (r % 2 == 0) begin
                if (c % 2 == 0) m_g1 = p;
                else            mbuf[c/2] = {m_g1, p};
            end else if (c % 2 == 0) begin
                m_b = p;
            end else begin
                gs    = {1'b0, mbuf[c/2][23:12]} + {1'b0, p};
                gh    = gs >> 1;
                e.x   = 9'(c / 2);
                e.y   = 9'(r / 2);
                e.rgb = tp ? {e.x[8:5], e.y[7:4], 4'h0} : {mbuf[c/2][11:8], gh[11:8], m_b[11:8]};
                e.cyc = cyc + 1;
                q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic send_line(input int r, input int len, input bit rnd, input bit track);
        logic [11:0] p;
        for (int c = 0; c < len; c++) begin
            if (rnd)             p = 12'($urandom);
            else if (r % 2 == 0) p = (c % 2 == 0) ? 12'hA00 : 12'hF00;
            else                 p = (c % 2 == 0) ? 12'h100 : 12'hA00;
            send_pix(r, c, p, track);
        end
        lv = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic frame_start();
        fv = 1'b1;
        lv = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic frame_end();
        lv = 1'b0;
        fv = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        int u0, f0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_update", 32'(upd), 32'd0);
        check("rst_posx", 32'(pos_x), 32'd0);
        check("rst_posy", 32'(pos_y), 32'd0);
        check("rst_rgb", 32'(rgb), 32'd0);
        check("rst_framedone", 32'(done), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Flat full frame
        u0 = n_upd; f0 = n_fd;
        frame_start();
        for (int r = 0; r < H; r++) send_line(r, W, 1'b0, 1'b1);
        frame_end();
        check("flat_updates", 32'(n_upd - u0), 32'(W * H / 4));
        check("flat_last_x", 32'(last_x), 32'(W / 2 - 1));
        check("flat_last_y", 32'(last_y), 32'(H / 2 - 1));
        check("flat_rgb", 32'(last_rgb), 32'hFA1);
        check("flat_framedone", 32'(n_fd - f0), 32'd1);
        check("flat_queue_empty", 32'(q.size()), 32'd0);

        // Green averaging and latency on quad (0,0)
        frame_start();
        send_pix(0, 0, 12'h800, 1'b1);
        send_pix(0, 1, 12'h5A5, 1'b1);
        lv = 1'b0;
        repeat (3) @(negedge clk);
        send_pix(1, 0, 12'h3C3, 1'b1);
        send_pix(1, 1, 12'h9FF, 1'b1);
        check("quad_update_latency", 32'(upd), 32'd1);
        check("quad_g_nibble", 32'(rgb[7:4]), 32'h8);
        check("quad_rgb", 32'(rgb), 32'h583);
        frame_end();

        // Over-long lines and extra rows are ignored
        u0 = n_upd; f0 = n_fd; max_x = '0;
        frame_start();
        for (int r = 0; r < H + 2; r++) send_line(r, W + 10, 1'b1, 1'b1);
        frame_end();
        check("long_updates", 32'(n_upd - u0), 32'(W * H / 4));
        check("long_max_x", 32'(max_x), 32'(W / 2 - 1));
        check("long_framedone", 32'(n_fd - f0), 32'd1);

        // Short even rows reuse stale buffer entries; odd-length odd row
        u0 = n_upd;
        frame_start();
        for (int r = 0; r < H; r++) send_line(r, (r % 2 == 0) ? 20 : ((r == 3) ? 21 : W), 1'b1, 1'b1);
        frame_end();
        check("short_updates", 32'(n_upd - u0), 32'd210);

        // Abort mid-line
        u0 = n_upd; f0 = n_fd;
        frame_start();
        for (int r = 0; r < 5; r++) send_line(r, W, 1'b1, 1'b1);
        for (int c = 0; c < 30; c++) send_pix(5, c, 12'($urandom), 1'b1);
        fv = 1'b0;
        lv = 1'b0;
        @(negedge clk);
        check("abort_framedone_pulse", 32'(done), 32'd1);
        @(negedge clk);
        check("abort_framedone_low", 32'(done), 32'd0);
        repeat (4) @(negedge clk);
        check("abort_updates", 32'(n_upd - u0), 32'd95);
        check("abort_framedone_count", 32'(n_fd - f0), 32'd1);
        check("abort_queue_empty", 32'(q.size()), 32'd0);
        frame_start();
        send_line(0, W, 1'b1, 1'b1);
        send_pix(1, 0, 12'($urandom), 1'b1);
        send_pix(1, 1, 12'($urandom), 1'b1);
        check("restart_update", 32'(upd), 32'd1);
        check("restart_posx", 32'(pos_x), 32'd0);
        check("restart_posy", 32'(pos_y), 32'd0);
        lv = 1'b0;
        repeat (4) @(negedge clk);
        frame_end();

        // Reset mid-line, released while FrameValid is high
        frame_start();
        send_line(0, W, 1'b1, 1'b1);
        for (int c = 0; c < 11; c++) send_pix(1, c, 12'($urandom), 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_update", 32'(upd), 32'd0);
        check("midrst_posx", 32'(pos_x), 32'd0);
        check("midrst_posy", 32'(pos_y), 32'd0);
        check("midrst_rgb", 32'(rgb), 32'd0);
        check("midrst_framedone", 32'(done), 32'd0);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        u0 = n_upd; f0 = n_fd;
        for (int c = 11; c < W; c++) send_pix(1, c, 12'($urandom), 1'b0);
        lv = 1'b0;
        repeat (4) @(negedge clk);
        for (int r = 2; r < 6; r++) send_line(r, W, 1'b1, 1'b0);
        frame_end();
        check("postrst_no_updates", 32'(n_upd - u0), 32'd0);
        check("postrst_no_framedone", 32'(n_fd - f0), 32'd0);

        // Clean frame after reset recovery
        u0 = n_upd; f0 = n_fd;
        frame_start();
        for (int r = 0; r < H; r++) send_line(r, W, 1'b1, 1'b1);
        frame_end();
        check("recover_updates", 32'(n_upd - u0), 32'(W * H / 4));
        check("recover_framedone", 32'(n_fd - f0), 32'd1);

`ifdef BAYER_BINNER_TEST_PATTERN_EN
        tp = 1'b1;
        u0 = n_upd;
        frame_start();
        for (int r = 0; r < H; r++) send_line(r, W, 1'b1, 1'b1);
        frame_end();
        check("tp_updates", 32'(n_upd - u0), 32'(W * H / 4));
        check("tp_last_rgb", 32'(last_rgb), 32'h100);
        tp = 1'b0;
`endif

        check("final_queue_empty", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
